// File: rtl/red_pitaya_trigger_gen_block_pkg.sv
// Shared definitions for the trigger generator. These are the FSM state encoding and the
// register map, which is also used by the trigger block's address decode.
package red_pitaya_trigger_gen_block_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DELAY = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_DONE  = 3'd4
   } gen_state_t;

   localparam logic [15:0] ADDR_CTRL      = 16'h0100;
   localparam logic [15:0] ADDR_STOP      = 16'h0104;
   localparam logic [15:0] ADDR_CFG       = 16'h0108;
   localparam logic [15:0] ADDR_OUT_MASK  = 16'h010C;
   localparam logic [15:0] ADDR_START_SRC = 16'h0110;
   localparam logic [15:0] ADDR_DELAY     = 16'h0114;
   localparam logic [15:0] ADDR_HIGH_LEN  = 16'h0118;
   localparam logic [15:0] ADDR_LOW_LEN   = 16'h011C;
   localparam logic [15:0] ADDR_N_PULSES  = 16'h0120;
   localparam logic [15:0] ADDR_PULSES    = 16'h0124;
   localparam logic [15:0] ADDR_CTR_LO    = 16'h015C;
   localparam logic [15:0] ADDR_CTR_HI    = 16'h0160;
   localparam logic [15:0] ADDR_TS_LO     = 16'h0164;
   localparam logic [15:0] ADDR_TS_HI     = 16'h0168;

   // Status word layout: {state[2:0], busy}
   function automatic logic [31:0] status_word(input gen_state_t st);
      return {28'd0, st, (st != ST_IDLE)};
   endfunction

endpackage

// File: rtl/red_pitaya_trigger_gen_timer.sv
// Loadable down-counter that times each FSM state. Load wins over count enable. The expire
// flag is high while the count sits at 1, which marks the last cycle of the state.
module red_pitaya_trigger_gen_timer #(
   parameter int WIDTH = 32
)(
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             expire
);

   logic [WIDTH-1:0] cnt;

   // Reload on state entry, otherwise count down and stop at zero.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && (cnt != '0))
         cnt <= cnt - WIDTH'(1);
   end

   assign expire = (cnt == WIDTH'(1));

endmodule

// File: rtl/red_pitaya_trigger_gen_block.sv
// Trigger bus pulse-burst generator with a sysbus register interface.
//
//  state | meaning
//  IDLE  | waiting for a software start strobe or a qualified external rising edge
//  DELAY | start delay, lasting the snapshotted delay cycles
//  HIGH  | pulse high, lasting max(high_len,1) cycles
//  LOW   | pulse low, lasting max(low_len,1) cycles
//  DONE  | one cycle at the end of a burst, then restart or go idle
module red_pitaya_trigger_gen_block
   import red_pitaya_trigger_gen_block_pkg::*;
#(
   parameter int CNTBITS = 32,
   parameter int TSBITS  = 64
)(
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [15:0] trig_i,
   output logic [15:0] trig_o,
   output logic        pulse_o,
   output logic        busy_o,
   input  logic [15:0] addr,
   input  logic        wen,
   input  logic        ren,
   output logic        ack,
   output logic [31:0] rdata,
   input  logic [31:0] wdata
);

   logic               auto_restart, ext_en;
   logic [15:0]        out_mask, start_src;
   logic [CNTBITS-1:0] delay_r, high_len, low_len, n_pulses;
   logic [CNTBITS-1:0] snap_delay, snap_high, snap_low, snap_n;
   logic [CNTBITS-1:0] pulses_emitted;
   logic               start_q, stop_q, ext_q, start_req;
   logic [15:0]        trig_s0, trig_s1, trig_s2;
   logic [TSBITS-1:0]  ctr, timestamp;
   logic [63:0]        ctr_w, ts_w;
   gen_state_t         state, state_nx;
   logic               tmr_load, tmr_expire;
   logic [CNTBITS-1:0] tmr_val;
   logic               do_start, do_restart, enter_high, pulse_d;
   logic [31:0]        rd_mux;

   // A zero length still gives a one-cycle HIGH or LOW phase.
   function automatic logic [CNTBITS-1:0] at_least_one(input logic [CNTBITS-1:0] v);
      return (v == '0) ? CNTBITS'(1) : v;
   endfunction

   // Configuration registers and the one-cycle start/stop strobes.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         auto_restart <= 1'b0;
         ext_en       <= 1'b0;
         out_mask     <= '0;
         start_src    <= '0;
         delay_r      <= '0;
         high_len     <= CNTBITS'(1);
         low_len      <= CNTBITS'(1);
         n_pulses     <= '0;
         start_q      <= 1'b0;
         stop_q       <= 1'b0;
      end else begin
         start_q <= wen && (addr == ADDR_CTRL);
         stop_q  <= wen && (addr == ADDR_STOP);
         if (wen) begin
            case (addr)
               ADDR_CFG:       {auto_restart, ext_en} <= wdata[1:0];
               ADDR_OUT_MASK:  out_mask  <= wdata[15:0];
               ADDR_START_SRC: start_src <= wdata[15:0];
               ADDR_DELAY:     delay_r   <= wdata[CNTBITS-1:0];
               ADDR_HIGH_LEN:  high_len  <= wdata[CNTBITS-1:0];
               ADDR_LOW_LEN:   low_len   <= wdata[CNTBITS-1:0];
               ADDR_N_PULSES:  n_pulses  <= wdata[CNTBITS-1:0];
               default: ;
            endcase
         end
      end
   end

   // Two-flop synchroniser, an edge-history flop, and a registered external start pulse.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         trig_s0 <= '0;
         trig_s1 <= '0;
         trig_s2 <= '0;
         ext_q   <= 1'b0;
      end else begin
         trig_s0 <= trig_i;
         trig_s1 <= trig_s0;
         trig_s2 <= trig_s1;
         ext_q   <= ext_en && (|(trig_s1 & ~trig_s2 & start_src));
      end
   end

   assign start_req = start_q | ext_q;

   // FSM state register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // Next state and timer reload. Leaving IDLE uses the live registers because the snapshot
   // is taken on that same edge.
   always_comb begin
      state_nx   = state;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      do_start   = 1'b0;
      do_restart = 1'b0;
      enter_high = 1'b0;
      if (stop_q) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_req) begin
                  do_start = 1'b1;
                  tmr_load = 1'b1;
                  if (delay_r != '0) begin
                     state_nx = ST_DELAY;
                     tmr_val  = delay_r;
                  end else begin
                     state_nx   = ST_HIGH;
                     tmr_val    = at_least_one(high_len);
                     enter_high = 1'b1;
                  end
               end
            end
            ST_DELAY: begin
               if (tmr_expire) begin
                  state_nx   = ST_HIGH;
                  tmr_load   = 1'b1;
                  tmr_val    = at_least_one(snap_high);
                  enter_high = 1'b1;
               end
            end
            ST_HIGH: begin
               if (tmr_expire) begin
                  state_nx = ST_LOW;
                  tmr_load = 1'b1;
                  tmr_val  = at_least_one(snap_low);
               end
            end
            ST_LOW: begin
               if (tmr_expire) begin
                  if ((snap_n != '0) && (pulses_emitted == snap_n)) begin
                     state_nx = ST_DONE;
                  end else begin
                     state_nx   = ST_HIGH;
                     tmr_load   = 1'b1;
                     tmr_val    = at_least_one(snap_high);
                     enter_high = 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (auto_restart) begin
                  do_restart = 1'b1;
                  tmr_load   = 1'b1;
                  if (snap_delay != '0) begin
                     state_nx = ST_DELAY;
                     tmr_val  = snap_delay;
                  end else begin
                     state_nx   = ST_HIGH;
                     tmr_val    = at_least_one(snap_high);
                     enter_high = 1'b1;
                  end
               end else begin
                  state_nx = ST_IDLE;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // FSM outputs decoded from the current state.
   always_comb begin
      pulse_d = (state == ST_HIGH);
      busy_o  = (state != ST_IDLE);
   end

   // Registered bus drive so the trigger lines never glitch.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pulse_o <= 1'b0;
         trig_o  <= '0;
      end else begin
         pulse_o <= pulse_d;
         trig_o  <= out_mask & {16{pulse_d}};
      end
   end

   // Burst snapshot, pulse counting, free-running counter and last-pulse timestamp.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         snap_delay     <= '0;
         snap_high      <= '0;
         snap_low       <= '0;
         snap_n         <= '0;
         pulses_emitted <= '0;
         ctr            <= '0;
         timestamp      <= '0;
      end else begin
         ctr <= ctr + TSBITS'(1);
         if (do_start) begin
            snap_delay <= delay_r;
            snap_high  <= high_len;
            snap_low   <= low_len;
            snap_n     <= n_pulses;
         end
         // A restart begins a fresh count, otherwise an auto-restarted finite burst never ends.
         if (do_start || do_restart)
            pulses_emitted <= enter_high ? CNTBITS'(1) : '0;
         else if (enter_high && (pulses_emitted != '1))
            pulses_emitted <= pulses_emitted + CNTBITS'(1);
         if (enter_high)
            timestamp <= ctr;
      end
   end

   red_pitaya_trigger_gen_timer #(
      .WIDTH (CNTBITS)
   ) u_timer (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (busy_o),
      .expire   (tmr_expire)
   );

   assign ctr_w = 64'(ctr);
   assign ts_w  = 64'(timestamp);

   // Read-data decode; unmapped and write-only addresses read as zero.
   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_CTRL:      rd_mux = status_word(state);
         ADDR_CFG:       rd_mux = {30'd0, auto_restart, ext_en};
         ADDR_OUT_MASK:  rd_mux = {16'd0, out_mask};
         ADDR_START_SRC: rd_mux = {16'd0, start_src};
         ADDR_DELAY:     rd_mux = 32'(delay_r);
         ADDR_HIGH_LEN:  rd_mux = 32'(high_len);
         ADDR_LOW_LEN:   rd_mux = 32'(low_len);
         ADDR_N_PULSES:  rd_mux = 32'(n_pulses);
         ADDR_PULSES:    rd_mux = 32'(pulses_emitted);
         ADDR_CTR_LO:    rd_mux = ctr_w[31:0];
         ADDR_CTR_HI:    rd_mux = ctr_w[63:32];
         ADDR_TS_LO:     rd_mux = ts_w[31:0];
         ADDR_TS_HI:     rd_mux = ts_w[63:32];
         default:        rd_mux = '0;
      endcase
   end

   // Bus acknowledge and registered read data.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ack   <= 1'b0;
         rdata <= '0;
      end else begin
         ack   <= wen | ren;
         rdata <= ren ? rd_mux : '0;
      end
   end

endmodule
